// File: rtl/gf180mcu_fd_sc_mcu9t5v0__drv_leg_ctrl_if.sv
// Request handshake between a level requester and the driver-leg controller.
interface gf180mcu_fd_sc_mcu9t5v0__drv_leg_ctrl_if;
    logic       REQ_VALID;
    logic [3:0] REQ_LVL;
    logic       REQ_READY;

    modport master (output REQ_VALID, output REQ_LVL, input REQ_READY);
    modport slave  (input REQ_VALID, input REQ_LVL, output REQ_READY);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__drv_leg_ctrl.sv
// Driver leg controller: ramps a registered thermometer enable toward a requested
// leg count, one leg per DWELL cycles, with synchronous emergency disable.
module gf180mcu_fd_sc_mcu9t5v0__drv_leg_ctrl #(
    parameter int unsigned NLEGS = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic                                            CLK,
    input  logic                                            RN,
    gf180mcu_fd_sc_mcu9t5v0__drv_leg_ctrl_if.slave          req,
    input  logic                                            FORCE_OFF,
    output logic [NLEGS-1:0]                                LEG_EN,
    output logic [3:0]                                      CUR_LVL,
    output logic                                            BUSY,
    output logic                                            DONE
);

    localparam logic [3:0] LP_NLEGS    = 4'(NLEGS);
    localparam logic [7:0] LP_DWELL_M1 = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [3:0]       r_tgt;
    logic [3:0]       r_lvl;
    logic [NLEGS-1:0] r_leg_en;
    logic             r_done;

    logic             w_ready;
    logic             w_accept;
    logic [3:0]       w_clamped;
    logic             w_step;
    logic [3:0]       w_step_lvl;

    function automatic logic [NLEGS-1:0] therm(input logic [3:0] lvl);
        for (int unsigned i = 0; i < NLEGS; i++) begin
            therm[i] = (i < 32'(lvl));
        end
    endfunction

    assign w_ready    = (r_state == IDLE) && !FORCE_OFF;
    assign w_accept   = req.REQ_VALID && w_ready;
    assign w_clamped  = (req.REQ_LVL > LP_NLEGS) ? LP_NLEGS : req.REQ_LVL;
    assign w_step     = (r_state != IDLE) && (r_cnt == LP_DWELL_M1);
    assign w_step_lvl = (r_state == RAMP_UP) ? r_lvl + 4'd1 : r_lvl - 4'd1;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tgt    <= '0;
            r_lvl    <= '0;
            r_leg_en <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (FORCE_OFF) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_tgt    <= '0;
                r_lvl    <= '0;
                r_leg_en <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_tgt <= w_clamped;
                            r_cnt <= '0;
                            if (w_clamped > r_lvl)      r_state <= RAMP_UP;
                            else if (w_clamped < r_lvl) r_state <= RAMP_DN;
                            else                        r_done  <= 1'b1;
                        end
                    end
                    RAMP_UP, RAMP_DN: begin
                        if (w_step) begin
                            r_cnt    <= '0;
                            r_lvl    <= w_step_lvl;
                            r_leg_en <= therm(w_step_lvl);
                            // Final step returns to IDLE so READY rises alongside DONE.
                            if (w_step_lvl == r_tgt) begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign req.REQ_READY = w_ready;
    assign LEG_EN        = r_leg_en;
    assign CUR_LVL       = r_lvl;
    assign BUSY          = (r_state != IDLE);
    assign DONE          = r_done;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__drv_leg_ctrl.md
GF180MCU_FD_SC_MCU9T5V0__DRV_LEG_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__drv_leg_ctrl

Interface
REQ-001 Parameter NLEGS, default 8, number of parallel inverter legs driven (legal 2..15).
REQ-002 Parameter DWELL, default 4, clock cycles between successive leg steps (legal 1..255).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RN  input  1  asynchronous active-low reset.
REQ-006 REQ_VALID  input  1  new target level offered.
REQ-007 REQ_LVL  input  4  requested number of enabled legs.
REQ-008 REQ_READY  output  1  block accepts a request this cycle.
REQ-009 FORCE_OFF  input  1  synchronous emergency disable of all legs.
REQ-010 LEG_EN  output  NLEGS  thermometer enable, one bit per inverter leg.
REQ-011 CUR_LVL  output  4  number of legs currently enabled.
REQ-012 BUSY  output  1  ramp in progress.
REQ-013 DONE  output  1  one-cycle pulse: target reached.

Function
REQ-014 LEG_EN[i] SHALL be 1 iff i < CUR_LVL; LEG_EN SHALL come directly from registers, glitch-free, no combinational path from any input.
REQ-015 FSM states: IDLE, RAMP_UP, RAMP_DN; BUSY = 1 in RAMP_UP/RAMP_DN only.
REQ-016 REQ_READY SHALL be 1 iff state is IDLE and FORCE_OFF = 0.
REQ-017 Handshake: request accepted on a rising edge where REQ_VALID = 1 and REQ_READY = 1; REQ_LVL sampled at that edge.
REQ-018 Accepted REQ_LVL > NLEGS SHALL be clamped to NLEGS and stored as target.
REQ-019 Target > CUR_LVL -> RAMP_UP; target < CUR_LVL -> RAMP_DN; dwell counter cleared to 0 at acceptance.
REQ-020 Target = CUR_LVL -> remain IDLE, DONE = 1 for the cycle following the acceptance edge, LEG_EN unchanged.
REQ-021 In RAMP states the dwell counter SHALL increment each cycle; when it reaches DWELL-1, CUR_LVL moves by exactly 1 toward target and counter wraps to 0.
REQ-022 With acceptance at edge k, steps occur at edges k+DWELL, k+2*DWELL, ...; never more than one leg changes per edge.
REQ-023 At the edge applying the final step: state -> IDLE, DONE = 1 for exactly the following cycle, REQ_READY = 1 in that same cycle.
REQ-024 REQ_VALID while BUSY SHALL be ignored (no queueing); requester must hold until REQ_READY.
REQ-025 FORCE_OFF = 1 sampled at an edge SHALL, at that edge, set CUR_LVL = 0, LEG_EN = 0, state = IDLE, counter = 0, discard any target; DONE SHALL not pulse.
REQ-026 FORCE_OFF has priority over request acceptance and ramp steps in the same cycle.
REQ-027 CUR_LVL SHALL never exceed NLEGS nor wrap below 0.

Reset
REQ-028 RN low SHALL immediately (asynchronously) force LEG_EN = 0, CUR_LVL = 0, BUSY = 0, DONE = 0, state IDLE, counter 0, target 0.
REQ-029 Reset mid-ramp SHALL abandon the ramp; after RN release REQ_READY = 1 (if FORCE_OFF = 0) with no DONE pulse.
REQ-030 First request SHALL be accepted on the first rising edge after RN deasserts.

Verification
REQ-031 Reset, DWELL=4, request REQ_LVL=3 at edge k -> CUR_LVL 1/2/3 at edges k+4/k+8/k+12, LEG_EN 8'h01/8'h03/8'h07, DONE one cycle after k+12, BUSY low thereafter.
REQ-032 From CUR_LVL=3 request REQ_LVL=0 -> LEG_EN 8'h03, 8'h01, 8'h00 at 4-cycle spacing, one DONE pulse.
REQ-033 Request REQ_LVL=15 with NLEGS=8 -> ramps to 8, LEG_EN = 8'hFF, no further steps.
REQ-034 Request equal to CUR_LVL -> DONE next cycle, BUSY never high, LEG_EN unchanged.
REQ-035 FORCE_OFF pulsed mid-ramp at CUR_LVL=5 -> LEG_EN = 8'h00 at that edge, no DONE, REQ_READY returns after FORCE_OFF low; REQ_VALID during ramp ignored.
REQ-036 RN asserted mid-ramp between clock edges -> LEG_EN = 0 without a clock edge; clean restart after release.
